// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter for downloader (DL), eraser (ER) and VDC.
// Fixed priority DL > ER > VDC, except that a VDC request that has waited
// MAX_WAIT cycles jumps the queue. Every RAM access takes one ISSUE cycle.
// VDC reads spend one extra CAPTURE cycle so that ram_q can be registered.
module mem_arbiter #(
    parameter int ADDR_W   = 18,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_ack,

    input  logic              er_req,
    input  logic [ADDR_W-1:0] er_addr,
    input  logic [7:0]        er_data,
    output logic              er_ack,

    input  logic              vdc_req,
    input  logic              vdc_wr,
    input  logic [ADDR_W-1:0] vdc_addr,
    input  logic [7:0]        vdc_wdata,
    output logic              vdc_ack,
    output logic [7:0]        vdc_rdata,
    output logic              vdc_rvalid,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    output logic              ram_en,
    input  logic [7:0]        ram_q,

    output logic              busy_blank
);

    localparam int DATA_W = 8;
    localparam int WC_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DL   = 2'd1,
        OWN_ER   = 2'd2,
        OWN_VDC  = 2'd3
    } owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              rd_q, rd_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic              win_dl, win_er, win_vdc;
    logic              vdc_grant;

    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_din_d;
    logic              ram_we_d, ram_en_d;
    logic              dl_ack_d, er_ack_d, vdc_ack_d;
    logic [DATA_W-1:0] vdc_rdata_d;
    logic              vdc_rvalid_d;
    logic              busy_blank_d;

    // Saturating increment for the VDC starvation counter.
    function automatic logic [WC_W-1:0] sat_inc(input logic [WC_W-1:0] v);
        if (v >= WC_MAX)
            return WC_MAX;
        return v + 1'b1;
    endfunction

    // Pick the requester that would win if the arbiter sampled this cycle.
    always_comb begin
        win_dl  = 1'b0;
        win_er  = 1'b0;
        win_vdc = 1'b0;
        if (vdc_req && (wait_cnt_q >= WC_MAX))
            win_vdc = 1'b1;
        else if (dl_req)
            win_dl = 1'b1;
        else if (er_req)
            win_er = 1'b1;
        else if (vdc_req)
            win_vdc = 1'b1;
    end

    // Next-state and next-output computation; RAM strobes and acks default low.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rd_d         = rd_q;
        ram_addr_d   = ram_addr;
        ram_din_d    = ram_din;
        ram_we_d     = 1'b0;
        ram_en_d     = 1'b0;
        dl_ack_d     = 1'b0;
        er_ack_d     = 1'b0;
        vdc_ack_d    = 1'b0;
        vdc_rdata_d  = vdc_rdata;
        vdc_rvalid_d = 1'b0;
        vdc_grant    = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_dl) begin
                    state_d    = ISSUE;
                    owner_d    = OWN_DL;
                    rd_d       = 1'b0;
                    ram_addr_d = dl_addr;
                    ram_din_d  = dl_data;
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    dl_ack_d   = 1'b1;
                end else if (win_er) begin
                    state_d    = ISSUE;
                    owner_d    = OWN_ER;
                    rd_d       = 1'b0;
                    ram_addr_d = er_addr;
                    ram_din_d  = er_data;
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    er_ack_d   = 1'b1;
                end else if (win_vdc) begin
                    state_d    = ISSUE;
                    owner_d    = OWN_VDC;
                    rd_d       = ~vdc_wr;
                    ram_addr_d = vdc_addr;
                    // A read leaves the last write data on ram_din.
                    if (vdc_wr)
                        ram_din_d = vdc_wdata;
                    ram_en_d   = 1'b1;
                    ram_we_d   = vdc_wr;
                    vdc_ack_d  = 1'b1;
                    vdc_grant  = 1'b1;
                end
            end
            ISSUE: begin
                state_d = rd_q ? CAPTURE : IDLE;
            end
            CAPTURE: begin
                vdc_rdata_d  = ram_q;
                vdc_rvalid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (vdc_grant || !vdc_req)
            wait_cnt_d = '0;
        else
            wait_cnt_d = sat_inc(wait_cnt_q);

        busy_blank_d = dl_req | er_req |
                       ((state_q != IDLE) && ((owner_q == OWN_DL) || (owner_q == OWN_ER)));
    end

    // FSM state, owner and starvation counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_NONE;
            rd_q       <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rd_q       <= rd_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Registered outputs; reset clears everything, including held data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_we     <= 1'b0;
            ram_en     <= 1'b0;
            dl_ack     <= 1'b0;
            er_ack     <= 1'b0;
            vdc_ack    <= 1'b0;
            vdc_rdata  <= '0;
            vdc_rvalid <= 1'b0;
            busy_blank <= 1'b0;
        end else begin
            ram_addr   <= ram_addr_d;
            ram_din    <= ram_din_d;
            ram_we     <= ram_we_d;
            ram_en     <= ram_en_d;
            dl_ack     <= dl_ack_d;
            er_ack     <= er_ack_d;
            vdc_ack    <= vdc_ack_d;
            vdc_rdata  <= vdc_rdata_d;
            vdc_rvalid <= vdc_rvalid_d;
            busy_blank <= busy_blank_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven single accesses, hand-written multi-cycle
// sequences, then randomized requesters checked against a timeline model.
module tb_mem_arbiter;

    localparam int ADDR_W   = 18;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              dl_req, er_req, vdc_req, vdc_wr;
    logic [ADDR_W-1:0] dl_addr, er_addr, vdc_addr;
    logic [7:0]        dl_data, er_data, vdc_wdata;
    logic              dl_ack, er_ack, vdc_ack;
    logic [7:0]        vdc_rdata;
    logic              vdc_rvalid;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we, ram_en;
    logic [7:0]        ram_q;
    logic              busy_blank;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
        .er_req(er_req), .er_addr(er_addr), .er_data(er_data), .er_ack(er_ack),
        .vdc_req(vdc_req), .vdc_wr(vdc_wr), .vdc_addr(vdc_addr), .vdc_wdata(vdc_wdata),
        .vdc_ack(vdc_ack), .vdc_rdata(vdc_rdata), .vdc_rvalid(vdc_rvalid),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_en(ram_en),
        .ram_q(ram_q), .busy_blank(busy_blank)
    );

    always #5 clk = ~clk;

    // RAM content is a fixed function of the address, so expected read data is known.
    function automatic logic [7:0] rom(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h78;
    endfunction

    // Synchronous-read RAM: ram_q valid the cycle after ram_en.
    always @(posedge clk) begin
        if (ram_en && !ram_we)
            ram_q <= rom(ram_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] acks();
        return {dl_ack, er_ack, vdc_ack};
    endfunction

    task automatic drop_all;
        dl_req  = 1'b0;
        er_req  = 1'b0;
        vdc_req = 1'b0;
    endtask

    typedef struct {
        string             name;
        logic [2:0]        who;      // {dl, er, vdc}
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              exp_we;
        logic [7:0]        exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        dl_req  = v.who[2];
        er_req  = v.who[1];
        vdc_req = v.who[0];
        dl_addr = v.addr; er_addr = v.addr; vdc_addr = v.addr;
        dl_data = v.data; er_data = v.data; vdc_wdata = v.data;
        vdc_wr  = v.wr;
        tick;
        chk({v.name, " ack"}, 32'(acks()), 32'(v.who));
        chk({v.name, " en"}, 32'(ram_en), 32'd1);
        chk({v.name, " we"}, 32'(ram_we), 32'(v.exp_we));
        chk({v.name, " addr"}, 32'(ram_addr), 32'(v.addr));
        if (v.exp_we)
            chk({v.name, " din"}, 32'(ram_din), 32'(v.data));
        drop_all;
        tick;
        chk({v.name, " ack c2"}, 32'(acks()), 32'd0);
        chk({v.name, " en c2"}, 32'(ram_en), 32'd0);
        tick;
        chk({v.name, " rvalid c3"}, 32'(vdc_rvalid), 32'(!v.exp_we));
        if (!v.exp_we)
            chk({v.name, " rdata"}, 32'(vdc_rdata), 32'(v.exp_rdata));
    endtask

    // Timeline model state for the random phase.
    int                m_free, m_wc, m_rd_pend, who;
    logic              m_prev_dlr, m_gv;
    logic [ADDR_W-1:0] m_rd_addr, m_addr;
    logic [7:0]        m_din, m_rdata;
    logic [2:0]        m_ack;
    logic              m_en, m_we, m_rvalid, m_busy;
    logic [2:0]        exp_seq [8];

    initial begin
        reset_n = 1'b0;
        drop_all;
        vdc_wr = 1'b0;
        dl_addr = '0; er_addr = '0; vdc_addr = '0;
        dl_data = '0; er_data = '0; vdc_wdata = '0;
        ram_q = '0;

        vecs[0] = '{"dl_wr",  3'b100, 1'b1, 18'h0C000, 8'hA5, 1'b1, 8'h00};
        vecs[1] = '{"er_wr",  3'b010, 1'b1, 18'h3FFFF, 8'h00, 1'b1, 8'h00};
        vecs[2] = '{"vdc_wr", 3'b001, 1'b1, 18'h00001, 8'hC3, 1'b1, 8'h00};
        vecs[3] = '{"vdc_rd123", 3'b001, 1'b0, 18'h00123, 8'h11, 1'b0, 8'h5A};
        vecs[4] = '{"vdc_rdmax", 3'b001, 1'b0, 18'h3FFFF, 8'h22, 1'b0, 8'h78};
        vecs[5] = '{"vdc_rdmix", 3'b001, 1'b0, 18'h2AB54, 8'h33, 1'b0, 8'h87};
        vecs[6] = '{"dl_wr0", 3'b100, 1'b1, 18'h00000, 8'hFF, 1'b1, 8'h00};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst ack", 32'(acks()), 32'd0);
        chk("rst ram", 32'({ram_en, ram_we, ram_addr, ram_din}), 32'd0);
        chk("rst vdc", 32'({vdc_rvalid, vdc_rdata, busy_blank}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Isolated accesses from the table
        foreach (vecs[i]) run_vec(vecs[i]);

        // DL write: busy_blank follows request then ownership, then drops
        dl_req = 1'b1; dl_addr = 18'h0C000; dl_data = 8'hA5;
        tick;
        chk("dl busy c1", 32'(busy_blank), 32'd1);
        chk("dl strobe c1", 32'({ram_en, ram_we, dl_ack}), 32'h7);
        dl_req = 1'b0;
        tick;
        chk("dl busy c2", 32'(busy_blank), 32'd1);
        chk("dl addr hold", 32'({ram_en, ram_addr, ram_din}), 32'({1'b0, 18'h0C000, 8'hA5}));
        tick;
        chk("dl busy c3", 32'(busy_blank), 32'd0);

        // All three at once: DL, ER, VDC read in order
        exp_seq = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
        dl_req = 1'b1; er_req = 1'b1; vdc_req = 1'b1; vdc_wr = 1'b0;
        vdc_addr = 18'h00456; er_addr = 18'h00010; dl_addr = 18'h00020;
        for (int c = 1; c <= 7; c++) begin
            tick;
            chk($sformatf("triple ack c%0d", c), 32'(acks()), 32'(exp_seq[c]));
            if (exp_seq[c][2]) dl_req = 1'b0;
            if (exp_seq[c][1]) er_req = 1'b0;
            if (exp_seq[c][0]) vdc_req = 1'b0;
        end
        chk("triple rvalid", 32'(vdc_rvalid), 32'd1);
        chk("triple rdata", 32'(vdc_rdata), 32'(rom(18'h00456)));

        // DL held continuously: VDC wins once starved, before the 3rd DL write
        exp_seq = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b100};
        dl_req = 1'b1; vdc_req = 1'b1; vdc_wr = 1'b1; vdc_wdata = 8'h3C;
        for (int c = 1; c <= 7; c++) begin
            tick;
            chk($sformatf("starve ack c%0d", c), 32'(acks()), 32'(exp_seq[c]));
            if (exp_seq[c][0]) vdc_req = 1'b0;
        end
        dl_req = 1'b0;
        repeat (2) tick;

        // VDC pulse while DL owns the RAM produces nothing
        dl_req = 1'b1; dl_addr = 18'h00777;
        tick;
        chk("pulse dl ack", 32'(acks()), 32'b100);
        dl_req = 1'b0; vdc_req = 1'b1; vdc_wr = 1'b0; vdc_addr = 18'h00999;
        tick;
        vdc_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            chk($sformatf("pulse quiet c%0d", c), 32'({vdc_ack, ram_en, vdc_rvalid}), 32'd0);
        end

        // Reset during CAPTURE aborts the read
        vdc_req = 1'b1; vdc_wr = 1'b0; vdc_addr = 18'h00123;
        tick;
        chk("abort ack", 32'(vdc_ack), 32'd1);
        vdc_req = 1'b0;
        tick;
        reset_n = 1'b0;
        #1;
        chk("abort outs", 32'({acks(), ram_en, ram_we, vdc_rvalid, busy_blank}), 32'd0);
        chk("abort data", 32'({ram_addr, ram_din}), 32'd0);
        chk("abort rdata", 32'(vdc_rdata), 32'd0);
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk($sformatf("abort quiet c%0d", c), 32'({acks(), vdc_rvalid, ram_en}), 32'd0);
        end

        // Randomized requesters against the timeline model
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_free = 0; m_wc = 0; m_rd_pend = 0; m_prev_dlr = 1'b0;
        m_addr = '0; m_din = '0; m_rdata = '0; m_rd_addr = '0;
        for (int k = 0; k < 800; k++) begin
            m_busy   = dl_req | er_req | m_prev_dlr;
            m_rvalid = (m_rd_pend == 1);
            if (m_rvalid) m_rdata = rom(m_rd_addr);
            if (m_rd_pend > 0) m_rd_pend--;
            m_ack = 3'b000; m_en = 1'b0; m_we = 1'b0; m_gv = 1'b0; m_prev_dlr = 1'b0;
            if (m_free == 0 && (dl_req || er_req || vdc_req)) begin
                if (vdc_req && m_wc >= MAX_WAIT) who = 2;
                else if (dl_req) who = 0;
                else if (er_req) who = 1;
                else who = 2;
                m_en = 1'b1;
                if (who == 0) begin
                    m_ack = 3'b100; m_addr = dl_addr; m_din = dl_data; m_we = 1'b1;
                    m_prev_dlr = 1'b1; m_free = 1;
                end else if (who == 1) begin
                    m_ack = 3'b010; m_addr = er_addr; m_din = er_data; m_we = 1'b1;
                    m_prev_dlr = 1'b1; m_free = 1;
                end else begin
                    m_ack = 3'b001; m_addr = vdc_addr; m_we = vdc_wr; m_gv = 1'b1;
                    if (vdc_wr) begin
                        m_din = vdc_wdata; m_free = 1;
                    end else begin
                        m_free = 2; m_rd_pend = 2; m_rd_addr = vdc_addr;
                    end
                end
            end else if (m_free > 0) begin
                m_free--;
            end
            if (m_gv || !vdc_req) m_wc = 0;
            else if (m_wc < MAX_WAIT) m_wc++;

            tick;
            chk($sformatf("rnd%0d ack", k), 32'(acks()), 32'(m_ack));
            chk($sformatf("rnd%0d ram", k), 32'({ram_en, ram_we, ram_addr}), 32'({m_en, m_we, m_addr}));
            chk($sformatf("rnd%0d din", k), 32'(ram_din), 32'(m_din));
            chk($sformatf("rnd%0d rd", k), 32'({vdc_rvalid, vdc_rdata}), 32'({m_rvalid, m_rdata}));
            chk($sformatf("rnd%0d busy", k), 32'(busy_blank), 32'(m_busy));

            if (dl_req) begin
                if (m_ack[2] || $urandom_range(0, 19) == 0) dl_req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                dl_req = 1'b1; dl_addr = ADDR_W'($urandom); dl_data = 8'($urandom);
            end
            if (er_req) begin
                if (m_ack[1] || $urandom_range(0, 19) == 0) er_req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                er_req = 1'b1; er_addr = ADDR_W'($urandom); er_data = 8'($urandom);
            end
            if (vdc_req) begin
                if (m_ack[0] || $urandom_range(0, 19) == 0) vdc_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                vdc_req = 1'b1; vdc_wr = 1'($urandom_range(0, 1));
                vdc_addr = ADDR_W'($urandom); vdc_wdata = 8'($urandom);
            end
        end
        drop_all;
        repeat (4) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, RAM address width.
REQ-002 SHALL have parameter MAX_WAIT, default 4, VDC wait cycles before VDC overrides priority.
REQ-003 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port dl_req  in  1  downloader write request, held until dl_ack.
REQ-006 SHALL have port dl_addr  in  ADDR_W  downloader write address.
REQ-007 SHALL have port dl_data  in  8  downloader write data.
REQ-008 SHALL have port dl_ack  out  1  one-cycle downloader grant/complete pulse.
REQ-009 SHALL have port er_req  in  1  eraser write request, held until er_ack.
REQ-010 SHALL have port er_addr  in  ADDR_W  eraser write address.
REQ-011 SHALL have port er_data  in  8  eraser write data.
REQ-012 SHALL have port er_ack  out  1  one-cycle eraser grant pulse.
REQ-013 SHALL have port vdc_req  in  1  VDC access request, held until vdc_ack.
REQ-014 SHALL have port vdc_wr  in  1  VDC access type, 1=write 0=read.
REQ-015 SHALL have port vdc_addr  in  ADDR_W  VDC address.
REQ-016 SHALL have port vdc_wdata  in  8  VDC write data.
REQ-017 SHALL have port vdc_ack  out  1  one-cycle VDC grant pulse.
REQ-018 SHALL have port vdc_rdata  out  8  VDC read data, held until next read completes.
REQ-019 SHALL have port vdc_rvalid  out  1  one-cycle pulse, vdc_rdata valid.
REQ-020 SHALL have port ram_addr  out  ADDR_W  registered RAM address.
REQ-021 SHALL have port ram_din  out  8  registered RAM write data.
REQ-022 SHALL have port ram_we  out  1  registered RAM write enable.
REQ-023 SHALL have port ram_en  out  1  registered RAM port enable.
REQ-024 SHALL have port ram_q  in  8  RAM read data, valid one cycle after ram_en.
REQ-025 SHALL have port busy_blank  out  1  registered; high while downloader or eraser pending or owning RAM.

Function
REQ-026 SHALL implement FSM states IDLE, ISSUE, CAPTURE.
REQ-027 IDLE: if any req high, SHALL latch winner, its addr/data/type into output registers and go ISSUE; else stay IDLE.
REQ-028 Winner SHALL be VDC if vdc_req and wait_cnt >= MAX_WAIT; otherwise fixed priority DL > ER > VDC.
REQ-029 ISSUE: ram_en=1, ram_we=1 for DL/ER or VDC write, owner ack=1, all exactly this one cycle.
REQ-030 ISSUE SHALL go IDLE after writes, CAPTURE after VDC reads.
REQ-031 CAPTURE: SHALL register ram_q into vdc_rdata and pulse vdc_rvalid in the following cycle; then IDLE.
REQ-032 Latency: ack one cycle after req sampled in IDLE; vdc_rvalid two cycles after vdc_ack.
REQ-033 Throughput: one write per 2 cycles, one read per 3 cycles.
REQ-034 ram_en and ram_we SHALL be 0 in IDLE and CAPTURE; ram_addr/ram_din hold last values.
REQ-035 Requester SHALL drop req the cycle after ack; req still high in IDLE is a new request.
REQ-036 Req deasserted before grant SHALL produce no RAM access and no ack.
REQ-037 wait_cnt SHALL increment, saturating at MAX_WAIT, each cycle vdc_req high and VDC not granted; clear on VDC grant or vdc_req low.
REQ-038 Simultaneous DL+ER+VDC with wait_cnt < MAX_WAIT SHALL serve DL, ER, VDC in that order.
REQ-039 At most one ack SHALL be high in any cycle; ram_we never high without ram_en.
REQ-040 busy_blank SHALL be next-cycle registered (dl_req | er_req | DL/ER owner outside IDLE).

Reset
REQ-041 reset_n low SHALL immediately force IDLE, wait_cnt=0, all outputs 0 including vdc_rdata.
REQ-042 Reset during ISSUE or CAPTURE SHALL abort the access: no later ack or vdc_rvalid for it.

Verification
REQ-043 VDC read addr 0x00123, ram model returns 0x5A -> vdc_ack cycle 1, ram_en/!ram_we cycle 1, vdc_rvalid cycle 3, vdc_rdata=0x5A.
REQ-044 DL, ER, VDC req same cycle, MAX_WAIT=4 -> acks DL (c1), ER (c3), VDC (c5), one each.
REQ-045 dl_req held continuously, vdc_req high -> VDC granted after wait_cnt reaches 4, before 3rd DL write.
REQ-046 DL writes 0xA5 to 0x0C000 -> ram_addr=0x0C000, ram_din=0xA5, ram_we=ram_en=1 one cycle; busy_blank high then low after drop.
REQ-047 reset_n low during CAPTURE -> all outputs 0 immediately, no vdc_rvalid after release.
REQ-048 vdc_req pulsed one cycle while DL owns RAM -> no VDC access, no vdc_ack.
